// File: rtl/sram_port_arbiter.sv
// Shares a single-port 32x512 SRAM macro between the instruction-fetch and load/store ports.
// Round-robin arbitration; byte-masked stores become a read phase followed by a merged write phase.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_W-1:0]     i_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic                  d_req_we,
  input  logic [DATA_W/8-1:0]   d_req_wstrb,
  input  logic [DATA_W-1:0]     d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  input  logic [DATA_W-1:0]     sram_dout0
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {ARB, RMW_WR} state_e;

  state_e              state_q, state_d;
  logic                prio_d_q, prio_d_d;
  logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0]   rmw_data_q, rmw_data_d;
  logic [STRB_W-1:0]   rmw_strb_q, rmw_strb_d;
  logic                i_rsp_valid_q, i_rsp_valid_d;
  logic                d_rsp_valid_q, d_rsp_valid_d;

  logic                grant_i, grant_d;
  logic                d_full, d_partial;
  logic [DATA_W-1:0]   merged;

  assign d_full    = &d_req_wstrb;
  assign d_partial = d_req_we && (|d_req_wstrb) && !d_full;

  // Fetch wins unless the load/store port is also waiting and holds priority.
  assign grant_i = i_req_valid && (!d_req_valid || !prio_d_q);
  assign grant_d = d_req_valid && !grant_i;

  // Old word from the read phase, overlaid with the latched store bytes.
  always_comb begin
    merged = sram_dout0;
    for (int k = 0; k < STRB_W; k++) begin
      if (rmw_strb_q[k]) merged[8*k +: 8] = rmw_data_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    prio_d_d      = prio_d_q;
    rmw_addr_d    = rmw_addr_q;
    rmw_data_d    = rmw_data_q;
    rmw_strb_d    = rmw_strb_q;
    i_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_addr0    = '0;
    sram_din0     = '0;
    // Gating on rst_n forces idle pins and zero readies as soon as reset asserts.
    if (rst_n) begin
      case (state_q)
        ARB: begin
          if (grant_i) begin
            i_req_ready   = 1'b1;
            sram_csb0     = 1'b0;
            sram_addr0    = i_req_addr;
            prio_d_d      = 1'b1;
            i_rsp_valid_d = 1'b1;
          end else if (grant_d) begin
            d_req_ready = 1'b1;
            sram_csb0   = 1'b0;
            sram_addr0  = d_req_addr;
            prio_d_d    = 1'b0;
            if (d_partial) begin
              rmw_addr_d = d_req_addr;
              rmw_data_d = d_req_wdata;
              rmw_strb_d = d_req_wstrb;
              state_d    = RMW_WR;
            end else begin
              if (d_req_we && d_full) begin
                sram_web0 = 1'b0;
                sram_din0 = d_req_wdata;
              end
              d_rsp_valid_d = 1'b1;
            end
          end
        end
        RMW_WR: begin
          sram_csb0     = 1'b0;
          sram_web0     = 1'b0;
          sram_addr0    = rmw_addr_q;
          sram_din0     = merged;
          d_rsp_valid_d = 1'b1;
          state_d       = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      prio_d_q      <= 1'b0;
      rmw_addr_q    <= '0;
      rmw_data_q    <= '0;
      rmw_strb_q    <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_d_q      <= prio_d_d;
      rmw_addr_q    <= rmw_addr_d;
      rmw_data_q    <= rmw_data_d;
      rmw_strb_q    <= rmw_strb_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign i_rsp_rdata = sram_dout0;
  assign d_rsp_rdata = sram_dout0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-read SRAM macro.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [8:0]  i_req_addr;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [8:0]  d_req_addr;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_wdata, d_rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Macro model; preload port lets the bench seed words while the DUT is in reset.
  logic [31:0] mem [512];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  logic mon_en = 1'b0;
  int   web_pulses = 0;
  int   drsp_cnt = 0;
  always @(posedge clk) if (mon_en && !sram_csb0 && !sram_web0) web_pulses <= web_pulses + 1;
  always @(negedge clk) if (mon_en && d_rsp_valid) drsp_cnt <= drsp_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wstrb = '0; d_req_wdata = '0; d_req_addr = '0;
  endtask

  typedef struct {
    logic iv; logic [8:0] ia;
    logic dv; logic dwe; logic [3:0] ds; logic [31:0] dwd; logic [8:0] da;
    logic ei; logic ed; logic ecsb; logic eweb; logic [8:0] eaddr;
    logic cdin; logic [31:0] edin;
    logic eirsp; logic edrsp;
    logic crd; logic [31:0] erd;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Fetch stream 0..3, then full store / load / partial store / no-op store sequences.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 0,  0, 0,  0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1,  0, 0,  1, 0,  1, 'h1000};
    tbl[2]  = '{1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2,  0, 0,  1, 0,  1, 'h1001};
    tbl[3]  = '{1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 1, 3,  0, 0,  1, 0,  1, 'h1002};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0,  1, 0,  1, 'h1003};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  1, 0,  0, 0,  0, 0};
    tbl[6]  = '{0, 0, 1, 1, 'hF, 'hDEADBEEF, 5,  0, 1, 0, 0, 5,  1, 'hDEADBEEF,  0, 0,  0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 5,  0, 1, 0, 1, 5,  0, 0,  0, 1,  0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0,  0, 1,  1, 'hDEADBEEF};
    tbl[9]  = '{0, 0, 1, 1, 'b0101, 'hAABBCCDD, 7,  0, 1, 0, 1, 7,  0, 0,  0, 0,  0, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 7,  0, 0, 0, 0, 7,  1, 'h11BB33DD,  0, 0,  0, 0};
    tbl[11] = '{1, 0, 1, 0, 0, 0, 7,  1, 0, 0, 1, 0,  0, 0,  0, 1,  0, 0};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 7,  0, 1, 0, 1, 7,  0, 0,  1, 0,  1, 'h1000};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0,  0, 1,  1, 'h11BB33DD};
    tbl[14] = '{0, 0, 1, 1, 0, 0, 5,  0, 1, 0, 1, 5,  0, 0,  0, 0,  0, 0};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 5,  0, 1, 0, 1, 5,  0, 0,  0, 1,  0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0,  0, 1,  1, 'hDEADBEEF};

    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("reset_i_rsp_valid", i_rsp_valid, 0);
    chk("reset_d_rsp_valid", d_rsp_valid, 0);
    chk("reset_csb0", sram_csb0, 1);
    chk("reset_web0", sram_web0, 1);
    for (int k = 0; k < 4; k++) preload(9'(k), 32'h1000 + 32'(k));
    preload(9'd7, 32'h11223344);
    preload(9'd9, 32'h0);
    preload(9'd5, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      i_req_valid = tbl[v].iv; i_req_addr = tbl[v].ia;
      d_req_valid = tbl[v].dv; d_req_we = tbl[v].dwe; d_req_wstrb = tbl[v].ds;
      d_req_wdata = tbl[v].dwd; d_req_addr = tbl[v].da;
      #1;
      chk($sformatf("v%0d_i_ready", v), i_req_ready, tbl[v].ei);
      chk($sformatf("v%0d_d_ready", v), d_req_ready, tbl[v].ed);
      chk($sformatf("v%0d_csb0", v), sram_csb0, tbl[v].ecsb);
      chk($sformatf("v%0d_web0", v), sram_web0, tbl[v].eweb);
      chk($sformatf("v%0d_addr0", v), sram_addr0, tbl[v].eaddr);
      if (tbl[v].cdin) chk($sformatf("v%0d_din0", v), sram_din0, tbl[v].edin);
      chk($sformatf("v%0d_i_rsp_valid", v), i_rsp_valid, tbl[v].eirsp);
      chk($sformatf("v%0d_d_rsp_valid", v), d_rsp_valid, tbl[v].edrsp);
      if (tbl[v].crd) begin
        chk($sformatf("v%0d_i_rsp_rdata", v), i_rsp_rdata, tbl[v].erd);
        chk($sformatf("v%0d_d_rsp_rdata", v), d_rsp_rdata, tbl[v].erd);
      end
    end

    // Both ports valid every cycle after reset: I, D, I, D.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 9'd1;
    d_req_valid = 1'b1; d_req_addr = 9'd2;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr%0d_i_ready", c), i_req_ready, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_d_ready", c), d_req_ready, (c % 2 == 1) ? 1 : 0);
      @(negedge clk);
    end
    chk("rr_d_rsp_before_reset", d_rsp_valid, 1);
    chk("rr_d_rsp_rdata", d_rsp_rdata, 32'h1002);

    // Asynchronous reset mid-traffic takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_d_rsp_valid", d_rsp_valid, 0);
    chk("async_rst_csb0", sram_csb0, 1);
    chk("async_rst_web0", sram_web0, 1);
    chk("async_rst_i_ready", i_req_ready, 0);
    chk("async_rst_d_ready", d_req_ready, 0);

    // Reset during the write phase of a partial store must leave memory untouched.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'b0011;
    d_req_wdata = 32'hFFFFFFFF; d_req_addr = 9'd9;
    #1;
    chk("rmw_rst_accept", d_req_ready, 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rmw_rst_write_phase", sram_web0, 0);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_web0_released", sram_web0, 1);
    idle_inputs();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("rmw_rst_web_pulses", web_pulses, 0);
    chk("rmw_rst_d_rsp_count", drsp_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 9'd9;
    #1;
    chk("rmw_rst_load_ready", d_req_ready, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rmw_rst_load_valid", d_rsp_valid, 1);
    chk("rmw_rst_load_rdata", d_rsp_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter and sequencer for the single-port 32x512 SRAM macro, which has a 1-cycle registered read and active-low chip select and write enable. It shares the macro between the instruction-fetch port (read-only) and the load/store port (read, full-word write, byte-masked write). The macro has no write mask, so byte-masked stores are performed as a read-modify-write. It sits between the RV32IM core's fetch/LSU and the on-chip SRAM.

## Interface
Parameters:
- ADDR_W, 9, word address width (512 words)
- DATA_W, 32, data width; byte lanes = DATA_W/8

Ports:
- clk  in  1  single clock; SRAM macro clocked from the same net
- rst_n  in  1  reset, asynchronous assert, active-low
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_W  fetch word address
- i_rsp_valid  out  1  fetch read data valid
- i_rsp_rdata  out  DATA_W  fetch read data
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store request accepted this cycle
- d_req_addr  in  ADDR_W  load/store word address
- d_req_we  in  1  1 = store
- d_req_wstrb  in  DATA_W/8  byte enables for stores
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  load data valid, or store complete
- d_rsp_rdata  out  DATA_W  load data; don't-care for stores
- sram_csb0  out  1  macro chip select, active-low
- sram_web0  out  1  macro write enable, active-low
- sram_addr0  out  ADDR_W  macro address
- sram_din0  out  DATA_W  macro write data
- sram_dout0  in  DATA_W  macro read data, valid the cycle after a selected access

## Operation
- States: ARB and RMW_WR. Reset state is ARB.
- ARB: the arbiter grants at most one valid requester per cycle.
  - If only one port is valid, that port is granted.
  - If both are valid, the round-robin pointer decides: the port not granted last wins.
  - The pointer updates on every grant. At reset it favours the fetch port.
- A grant raises that port's x_req_ready in the same cycle, combinationally from the valids. The SRAM is driven in that same cycle.
- SRAM drive per request type:
  - Fetch read, load, or store with wstrb==0: csb0=0, web0=1, addr0=req addr. A wstrb==0 store acts as a no-op and writes nothing.
  - Store with wstrb all-ones: csb0=0, web0=0, din0=wdata.
  - Store with a partial wstrb: csb0=0, web0=1 (read phase). Latch addr, wdata and wstrb, then go to RMW_WR.
- RMW_WR:
  - Both readies are 0.
  - csb0=0, web0=0, addr0=latched address.
  - din0 byte k = wstrb[k] ? wdata byte k : sram_dout0 byte k.
  - Return to ARB next cycle.
- Idle drive (no grant): csb0=1, web0=1, addr0=0, din0=0.
- Responses:
  - x_rsp_valid is a registered 1-cycle pulse.
  - x_rsp_rdata = sram_dout0, passed combinationally to both ports. It is meaningful only while x_rsp_valid=1.
  - Requesters have no response back-pressure; they must accept every response.
- Reset values: i_rsp_valid=0, d_rsp_valid=0, state=ARB, pointer=fetch, latches=0. Readies are 0 while rst_n=0. SRAM pins take the idle values.
- Reset mid-RMW (assert during RMW_WR): no write is issued, no response is produced, memory is unchanged.

## Timing
- Read, or full/no-op store: accepted at edge n (valid&&ready high in cycle n-1 → SRAM samples at edge n). rsp_valid is high in cycle n..n+1, i.e. one cycle after acceptance.
- Partial store: read phase in the accept cycle, write phase in the next cycle. d_rsp_valid pulses one cycle after the write phase, i.e. 2 cycles after acceptance.
- Throughput: one access per cycle in ARB. A partial store costs 2 SRAM cycles and blocks both ports for 1 cycle.
- Read-after-write to the same address in the next cycle (including right after RMW_WR) returns the new data; the macro write completes at the edge.
- Combinational paths: req_valid → ready/sram pins; sram_dout0 → rsp_rdata and sram_din0 (RMW).

## Test plan
- Reset: rst_n=0 mid-traffic → both rsp_valid=0, csb0=1, web0=1 on the same cycle, with no clock edge needed.
- Fetch only, addrs 0..3 back-to-back after preloading word k=0x1000+k → ready held 1, i_rsp_valid 1 cycle later with rdata 0x1000..0x1003 in order.
- Both ports valid every cycle → grants alternate I,D,I,D starting with I after reset; no port is granted twice in a row while the other is waiting.
- Full store 0xDEADBEEF @5, then load @5 next cycle → d_rsp_rdata=0xDEADBEEF.
- Word @7=0x11223344, store wstrb=4'b0101 wdata=0xAABBCCDD → readies 0 during RMW_WR, d_rsp_valid 2 cycles after accept, subsequent load returns 0x11BB33DD.
- rst_n asserted during RMW_WR of a partial store @9 (old 0x0) → no web0=0 pulse, no d_rsp_valid, load @9 after reset returns 0x0.
